// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier and
// restoring divider, feeding the registered EX/MEM outputs.
module ex_stage_md #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          En,
  input  logic          Clr,
  input  logic [DW-1:0] RefAddr,
  input  logic [DW-1:0] rData1,
  input  logic [DW-1:0] rData2_i,
  input  logic [DW-1:0] Offset,
  input  logic [RW-1:0] RtAddr,
  input  logic [RW-1:0] RdAddr,
  input  logic          DstReg,
  input  logic          ALUSrc,
  input  logic [3:0]    Op,
  output logic [DW-1:0] JumpAddr,
  output logic [DW-1:0] Result,
  output logic [DW-1:0] rData2,
  output logic          Zero,
  output logic [RW-1:0] wAddr,
  output logic          Stall
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] opb, alu_res, md_res, res_sel;
  logic          is_md, start, load;
  logic [DW-1:0] a_reg, b_reg, q_reg;
  logic [DW-1:0] a_next, b_next, q_next;
  logic [3:0]    op_reg;
  logic [CW-1:0] cnt_reg;
  logic [DW+1:0] trial;

  assign opb   = ALUSrc ? Offset : rData2_i;
  assign is_md = (Op == 4'd5) || (Op == 4'd6) || (Op == 4'd7);
  assign start = (state_reg == IDLE) && is_md && !Clr;
  assign load  = En && !Stall && !Clr;

  always_comb begin
    alu_res = '0;
    case (Op)
      4'd0:    alu_res = rData1 + opb;
      4'd1:    alu_res = rData1 - opb;
      4'd2:    alu_res = rData1 & opb;
      4'd3:    alu_res = rData1 | opb;
      4'd4:    alu_res = {{(DW-1){1'b0}}, ($signed(rData1) < $signed(opb))};
      default: alu_res = '0;
    endcase
  end

  // a_reg holds the product accumulator or the partial remainder; q_reg the
  // multiplier or the dividend shifting into the quotient.
  always_comb begin
    md_res = a_reg;
    if (op_reg == 4'd6) md_res = q_reg;
  end

  assign res_sel = (state_reg == DONE) ? md_res : alu_res;

  // One iteration step; the extra top bit of trial flags a failed subtract.
  always_comb begin
    trial  = {1'b0, a_reg, q_reg[DW-1]} - {2'b00, b_reg};
    a_next = a_reg;
    b_next = b_reg;
    q_next = q_reg;
    if (op_reg == 4'd5) begin
      a_next = q_reg[0] ? (a_reg + b_reg) : a_reg;
      b_next = b_reg << 1;
      q_next = q_reg >> 1;
    end else if (!trial[DW+1]) begin
      a_next = trial[DW-1:0];
      q_next = {q_reg[DW-2:0], 1'b1};
    end else begin
      a_next = {a_reg[DW-2:0], q_reg[DW-1]};
      q_next = {q_reg[DW-2:0], 1'b0};
    end
  end

  always_comb begin
    state_next = state_reg;
    Stall      = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        Stall      = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_reg == CW'(1)) state_next = DONE;
      end
      DONE: if (En) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (Clr) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      JumpAddr <= '0;
      Result   <= '0;
      Zero     <= 1'b0;
      rData2   <= '0;
      wAddr    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      q_reg    <= '0;
      op_reg   <= '0;
      cnt_reg  <= '0;
    end else begin
      if (Clr) begin
        JumpAddr <= '0;
        Result   <= '0;
        Zero     <= 1'b0;
        rData2   <= '0;
        wAddr    <= '0;
      end else if (load) begin
        JumpAddr <= RefAddr + (Offset << 2);
        Result   <= res_sel;
        Zero     <= (res_sel == '0);
        rData2   <= rData2_i;
        wAddr    <= DstReg ? RdAddr : RtAddr;
      end
      if (start) begin
        a_reg   <= '0;
        b_reg   <= opb;
        q_reg   <= rData1;
        op_reg  <= Op;
        cnt_reg <= CW'(DW);
      end else if (state_reg == BUSY) begin
        a_reg   <= a_next;
        b_reg   <= b_next;
        q_reg   <= q_next;
        cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU vector table plus hand-written
// multi-cycle, flush and reset sequences.
module tb_ex_stage_md;
  logic        clk = 1'b0;
  logic        rst, En, Clr, DstReg, ALUSrc, Zero, Stall;
  logic [31:0] RefAddr, rData1, rData2_i, Offset, JumpAddr, Result, rData2;
  logic [4:0]  RtAddr, RdAddr, wAddr;
  logic [3:0]  Op;
  int          total = 0;
  int          bad = 0;

  ex_stage_md #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .En(En), .Clr(Clr), .RefAddr(RefAddr), .rData1(rData1),
    .rData2_i(rData2_i), .Offset(Offset), .RtAddr(RtAddr), .RdAddr(RdAddr),
    .DstReg(DstReg), .ALUSrc(ALUSrc), .Op(Op), .JumpAddr(JumpAddr), .Result(Result),
    .rData2(rData2), .Zero(Zero), .wAddr(wAddr), .Stall(Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, off, refa;
    logic        alusrc, dst;
    logic [4:0]  rt, rd;
    logic [31:0] res;
    logic        zero;
    logic [31:0] jump;
    logic [4:0]  waddr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] off, input logic [31:0] refa, input logic alusrc,
                       input logic dst, input logic [4:0] rt, input logic [4:0] rd);
    Op = op; rData1 = a; rData2_i = b; Offset = off; RefAddr = refa;
    ALUSrc = alusrc; DstReg = dst; RtAddr = rt; RdAddr = rd;
  endtask

  // Starts a multi-cycle op, counts Stall-high cycles, then loads the result.
  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    drive(op, a, b, 32'h0, 32'h0, 1'b0, 1'b0, 5'd1, 5'd2);
    En = 1'b1; Clr = 1'b0;
    #1;
    n = 0;
    while (Stall && n < 100) begin
      tick();
      n++;
    end
    check({name, " stall cycles"}, n, 33);
    tick();
    check({name, " result"}, Result, exp);
    check({name, " zero"}, {31'b0, Zero}, {31'b0, exp == 32'h0});
    $display("md %s a=%h b=%h result=%h stall=%0d", name, a, b, Result, n);
    Op = 4'd0;
  endtask

  initial begin
    vecs[0]  = '{4'd0, 32'd7, 32'd5, 32'd0, 32'h1000, 1'b0, 1'b0, 5'd3, 5'd4, 32'd12, 1'b0, 32'h1000, 5'd3};
    vecs[1]  = '{4'd1, 32'd5, 32'd5, 32'd1, 32'h10, 1'b0, 1'b1, 5'd3, 5'd4, 32'd0, 1'b1, 32'h14, 5'd4};
    vecs[2]  = '{4'd0, 32'h10, 32'h55, 32'hFFFF_FFFC, 32'h100, 1'b1, 1'b1, 5'd2, 5'd9, 32'hC, 1'b0, 32'hF0, 5'd9};
    vecs[3]  = '{4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd2, 32'h0, 1'b0, 1'b0, 5'd1, 5'd7, 32'h00F0_1200, 1'b0, 32'h8, 5'd1};
    vecs[4]  = '{4'd3, 32'hF000_0000, 32'hF, 32'd0, 32'h4, 1'b0, 1'b0, 5'd31, 5'd0, 32'hF000_000F, 1'b0, 32'h4, 5'd31};
    vecs[5]  = '{4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b0, 1'b0, 5'd5, 5'd6, 32'd1, 1'b0, 32'h0, 5'd5};
    vecs[6]  = '{4'd4, 32'd5, 32'hFFFF_FFFE, 32'd0, 32'h0, 1'b0, 1'b0, 5'd5, 5'd6, 32'd0, 1'b1, 32'h0, 5'd5};
    vecs[7]  = '{4'd1, 32'd0, 32'd1, 32'h4000_0000, 32'h8, 1'b0, 1'b0, 5'd2, 5'd3, 32'hFFFF_FFFF, 1'b0, 32'h8, 5'd2};
    vecs[8]  = '{4'd0, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'h0, 1'b0, 1'b1, 5'd2, 5'd3, 32'd1, 1'b0, 32'hC, 5'd3};
    vecs[9]  = '{4'd9, 32'd3, 32'd4, 32'd0, 32'h0, 1'b0, 1'b0, 5'd8, 5'd9, 32'd0, 1'b1, 32'h0, 5'd8};
    vecs[10] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b0, 1'b0, 5'd8, 5'd9, 32'd0, 1'b1, 32'h0, 5'd8};

    rst = 1'b0; En = 1'b1; Clr = 1'b0;
    drive(4'd0, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b1, 5'd1, 5'd2);
    tick(); tick();
    check("reset result", Result, 32'h0);
    check("reset jump", JumpAddr, 32'h0);
    check("reset waddr", {27'b0, wAddr}, 32'h0);
    check("reset stall", {31'b0, Stall}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].refa,
            vecs[i].alusrc, vecs[i].dst, vecs[i].rt, vecs[i].rd);
      #1;
      check($sformatf("vec%0d stall", i), {31'b0, Stall}, 32'h0);
      tick();
      check($sformatf("vec%0d result", i), Result, vecs[i].res);
      check($sformatf("vec%0d zero", i), {31'b0, Zero}, {31'b0, vecs[i].zero});
      check($sformatf("vec%0d jump", i), JumpAddr, vecs[i].jump);
      check($sformatf("vec%0d waddr", i), {27'b0, wAddr}, {27'b0, vecs[i].waddr});
      check($sformatf("vec%0d rdata2", i), rData2, vecs[i].b);
      $display("vec %0d op=%0d result=%h zero=%0d jump=%h waddr=%0d",
               i, vecs[i].op, Result, Zero, JumpAddr, wAddr);
    end

    run_md("mulu max", 4'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_md("mulu small", 4'd5, 32'd123, 32'd456, 32'd56088);
    run_md("mulu wrap", 4'd5, 32'h0001_0000, 32'h0001_0000, 32'h0);
    run_md("divu", 4'd6, 32'd100, 32'd7, 32'd14);
    run_md("remu", 4'd7, 32'd100, 32'd7, 32'd2);
    run_md("divu by0", 4'd6, 32'd100, 32'd0, 32'hFFFF_FFFF);
    run_md("remu by0", 4'd7, 32'd100, 32'd0, 32'd100);
    run_md("back to back", 4'd6, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);

    // Flush during a divide.
    drive(4'd6, 32'd100, 32'd7, 32'd1, 32'h40, 1'b0, 1'b0, 5'd4, 5'd5);
    tick(); tick(); tick(); tick(); tick();
    Clr = 1'b1; Op = 4'd0;
    tick();
    Clr = 1'b0;
    #1;
    check("flush result", Result, 32'h0);
    check("flush jump", JumpAddr, 32'h0);
    check("flush waddr", {27'b0, wAddr}, 32'h0);
    check("flush stall", {31'b0, Stall}, 32'h0);
    $display("flush result=%h stall=%0d", Result, Stall);

    // Hold in DONE with En low, then release.
    drive(4'd0, 32'd9, 32'd9, 32'd0, 32'h0, 1'b0, 1'b0, 5'd1, 5'd2);
    tick();
    check("pre-hold result", Result, 32'd18);
    drive(4'd5, 32'd6, 32'd7, 32'd0, 32'h0, 1'b0, 1'b0, 5'd1, 5'd2);
    for (int i = 0; i < 33; i++) tick();
    En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d stall", i), {31'b0, Stall}, 32'h0);
      check($sformatf("hold%0d result", i), Result, 32'd18);
    end
    En = 1'b1;
    tick();
    check("hold release result", Result, 32'd42);
    $display("hold release result=%h", Result);
    Op = 4'd0;

    // Reset in the middle of a multiply.
    drive(4'd5, 32'd3, 32'd5, 32'd2, 32'h20, 1'b0, 1'b0, 5'd6, 5'd7);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0; Op = 4'd0;
    tick();
    check("mid rst result", Result, 32'h0);
    check("mid rst jump", JumpAddr, 32'h0);
    check("mid rst stall", {31'b0, Stall}, 32'h0);
    rst = 1'b1;
    $display("mid-reset result=%h stall=%0d", Result, Stall);
    run_md("after reset", 4'd5, 32'd3, 32'd5, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
